// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder built around one 1-bit full-add cell.
// Operands are captured on an accepted start, added LSB-first one bit per
// clock, and the result is published with a one-cycle done pulse.
module serial_adder #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  // One state bit per decoded output so busy/done come straight off flops.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] psum_q, psum_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fa_s_c;
  logic             fa_co_c;

  // Single full-add cell fed by the operand LSBs and the carry register.
  always_comb begin
    fa_s_c  = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
    fa_co_c = (a_sh_q[0] & b_sh_q[0]) | (carry_q & a_sh_q[0]) | (carry_q & b_sh_q[0]);
  end

  // Next-state and datapath update; every register holds unless its state acts.
  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    psum_d  = psum_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          psum_d  = '0;
          carry_d = cin;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        a_sh_d  = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d  = {1'b0, b_sh_q[WIDTH-1:1]};
        psum_d  = {fa_s_c, psum_q[WIDTH-1:1]};
        carry_d = fa_co_c;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_BIT) begin
          // Publish the completed word together with the final carry.
          sum_d   = {fa_s_c, psum_q[WIDTH-1:1]};
          cout_d  = fa_co_c;
          state_d = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset taking priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      psum_q  <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      psum_q  <= psum_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy = state_q[0];
  assign done = state_q[1];
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: randomized scoreboard bench for serial_adder (WIDTH=4).
module tb_serial_adder;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  typedef struct {
    logic [W-1:0] s;
    logic         co;
    int           due;
  } exp_t;

  exp_t         q[$];
  int           cyc      = 0;
  int           next_ok  = 0;
  int           checks   = 0;
  int           failures = 0;
  logic [W-1:0] held_s   = '0;
  logic         held_co  = 1'b0;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  always #5 clk = ~clk;

  // cyc = index of the clock period that follows the most recent rising edge
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, expv);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Reference: {cout,sum} = a + b + cin; result due WIDTH periods after the accepting edge.
  task automatic push_exp(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    exp_t        e;
    logic [W:0]  t;
    t     = (W+1)'(x) + (W+1)'(y) + (W+1)'(c);
    e.s   = t[W-1:0];
    e.co  = t[W];
    e.due = cyc + 1 + W;
    q.push_back(e);
    next_ok = cyc + 1 + W + 2;
  endtask

  // Wait until the DUT can accept, then present one start; noise pokes ignored starts meanwhile.
  task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic c, input bit noise);
    while (cyc + 1 < next_ok) begin
      if (noise) begin
        start = 1'($urandom);
        a     = W'($urandom);
        b     = W'($urandom);
        cin   = 1'($urandom);
      end else begin
        start = 1'b0;
      end
      step();
    end
    start = 1'b1;
    a     = x;
    b     = y;
    cin   = c;
    push_exp(x, y, c);
    step();
    start = 1'b0;
    a     = W'($urandom);
    b     = W'($urandom);
    cin   = 1'($urandom);
  endtask

  // Monitor: compares busy/done every period, pops the scoreboard on done, checks hold otherwise.
  always @(negedge clk) begin : mon
    logic eb;
    logic ed;
    if (rst) begin
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_sum",  32'(sum),  32'd0);
      chk("rst_cout", 32'(cout), 32'd0);
      held_s  = '0;
      held_co = 1'b0;
    end else begin
      ed = (q.size() > 0) && (cyc == q[0].due);
      eb = (q.size() > 0) && (cyc >= q[0].due - W) && (cyc < q[0].due);
      chk("busy", 32'(busy), 32'(eb));
      chk("done", 32'(done), 32'(ed));
      if (ed) begin
        chk("sum",  32'(sum),  32'(q[0].s));
        chk("cout", 32'(cout), 32'(q[0].co));
        held_s  = q[0].s;
        held_co = q[0].co;
        void'(q.pop_front());
      end else begin
        chk("sum_hold",  32'(sum),  32'(held_s));
        chk("cout_hold", 32'(cout), 32'(held_co));
      end
    end
  end

  initial begin : drv
    int guard;
    logic [8:0] v;
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    cin   = 1'b0;
    step();
    step();
    rst = 1'b0;

    // first start right after reset release, then the directed sums
    issue(4'h5, 4'h3, 1'b0, 1'b0);
    issue(4'hF, 4'h1, 1'b0, 1'b0);
    issue(4'hF, 4'hF, 1'b1, 1'b0);

    // start held high; operands change during SHIFT; second op taken right after done
    while (cyc + 1 < next_ok) step();
    start = 1'b1;
    a     = 4'h2;
    b     = 4'h2;
    cin   = 1'b0;
    push_exp(4'h2, 4'h2, 1'b0);
    step();
    a = 4'h7;
    b = 4'h7;
    while (cyc + 1 < next_ok) step();
    push_exp(4'h7, 4'h7, 1'b0);
    step();
    start = 1'b0;

    // reset during the second SHIFT period aborts without a done pulse
    issue(4'h9, 4'h9, 1'b0, 1'b0);
    step();
    rst = 1'b1;
    q.delete();
    step();
    rst     = 1'b0;
    next_ok = 0;
    issue(4'h9, 4'h9, 1'b0, 1'b0);

    // exhaustive sweep of every (a, b, cin)
    for (int i = 0; i < 512; i++) begin
      v = 9'(i);
      issue(v[3:0], v[7:4], v[8], 1'b0);
    end

    // random operands, random gaps, stray starts while busy
    repeat (150) begin
      repeat ($urandom_range(0, 3)) step();
      issue(W'($urandom), W'($urandom), 1'($urandom), 1'b1);
    end

    guard = 0;
    while (q.size() > 0 && guard < 50) begin
      step();
      guard++;
    end
    chk("drain", 32'(q.size()), 32'd0);
    repeat (3) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter: WIDTH, default 4, operand/result width in bits; SHALL be legal for 2..32.
REQ-002 clk  input  1  rising-edge clock; the only clock.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  request to begin an addition; sampled only in IDLE.
REQ-005 a  input  WIDTH  operand A; captured on accepted start.
REQ-006 b  input  WIDTH  operand B; captured on accepted start.
REQ-007 cin  input  1  carry-in; captured on accepted start.
REQ-008 busy  output  1  high while an addition is in progress (SHIFT state).
REQ-009 done  output  1  one-cycle pulse; sum/cout valid from this cycle.
REQ-010 sum  output  WIDTH  registered result, held until the next result.
REQ-011 cout  output  1  registered final carry-out, held with sum.

Function
REQ-012 The block SHALL add LSB-first, one bit per clock, using a single 1-bit full-add cell: s = x^y^c, co = x&y | c&x | c&y.
REQ-013 FSM states SHALL be IDLE, SHIFT, DONE; encoding is free.
REQ-014 IDLE + start=1: capture a, b into shift registers, carry_reg<=cin, bit counter<=0, go to SHIFT.
REQ-015 IDLE + start=0: remain in IDLE; no register changes.
REQ-016 SHIFT, each cycle: full-add a_sh[0], b_sh[0], carry_reg; shift a_sh, b_sh right by 1; shift s into MSB of the partial-sum register; carry_reg<=co; counter++.
REQ-017 SHIFT SHALL last exactly WIDTH cycles; on the cycle the counter equals WIDTH-1, go to DONE.
REQ-018 On entry to DONE, sum<=completed partial-sum register and cout<=final co; these outputs SHALL NOT change at any other time except reset.
REQ-019 DONE SHALL last exactly one cycle with done=1, then unconditionally return to IDLE.
REQ-020 Latency: start accepted at edge N -> busy=1 for cycles N+1..N+WIDTH; done=1 and sum/cout valid in cycle N+WIDTH+1.
REQ-021 start while in SHIFT or DONE SHALL be ignored; no queuing, no restart, operands unaffected.
REQ-022 Back-to-back: start asserted in the cycle after done (IDLE) SHALL be accepted; minimum issue interval is WIDTH+2 cycles.
REQ-023 Changes on a, b, cin after capture SHALL NOT affect the running result.
REQ-024 Arithmetic: {cout,sum} SHALL equal a + b + cin exactly, modulo 2^(WIDTH+1); no overflow flag.
REQ-025 busy SHALL be 1 iff state is SHIFT; done SHALL be 1 iff state is DONE; both are decoded from state registers only, with no combinational path from inputs.

Reset
REQ-026 rst=1 at a clock edge SHALL force state IDLE, busy=0, done=0, sum=0, cout=0, counter=0, carry_reg=0, shift registers=0.
REQ-027 rst SHALL take priority over start and over any FSM transition, including mid-SHIFT and in DONE; the aborted operation produces no done pulse.
REQ-028 The first start SHALL be accepted in the first cycle after rst is released.

Verification (WIDTH=4)
REQ-029 a=0x5, b=0x3, cin=0, start pulsed at edge N -> busy cycles N+1..N+4; done at N+5; sum=0x8, cout=0.
REQ-030 a=0xF, b=0x1, cin=0 -> sum=0x0, cout=1; a=0xF, b=0xF, cin=1 -> sum=0xF, cout=1.
REQ-031 start=1 held continuously with a=0x2, b=0x2, while a/b change to 0x7 during SHIFT -> one result sum=0x4, cout=0, then next op captured in the cycle after done with 0x7+0x7 -> sum=0xE, cout=0.
REQ-032 rst asserted in 2nd SHIFT cycle of a=0x9+b=0x9 -> next cycle all outputs 0, state IDLE, no done pulse; a fresh 0x9+0x9 afterwards -> sum=0x2, cout=1.
REQ-033 Exhaustive sweep of all 512 (a, b, cin) combinations, each compared with a+b+cin at done; sum/cout checked stable between done pulses.
